font_rom_arb: RTL and testbench

FONT_ROM_ARB -- requirements
Module: font_rom_arb

---
 rtl/font_rom_arb.sv | 115 +++++++++++
 tb/tb_font_rom_arb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/font_rom_arb.sv
// Four-way arbiter sharing one synchronous font ROM with a fixed 2-cycle response.
// Define FONT_ARB_RR_EN for round-robin grants; otherwise the lowest index wins.
module font_rom_arb #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req_valid,
  input  logic [4*AW-1:0] req_addr,
  output logic [3:0]      req_ready,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  output logic [3:0]      rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic [7:0]      conflict_cnt
);

  // Handshake: request i is accepted on a rising edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is one-hot or zero. Responses come
  // back as a one-cycle rsp_valid pulse two edges later and are never stalled.

  logic [3:0]    grant;
  logic [1:0]    grant_idx;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic          multi_req;

  logic [AW-1:0] rom_addr_q;
  logic          s1_v_q, s2_v_q;
  logic [1:0]    s1_tag_q, s2_tag_q;
  logic [3:0]    rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic [7:0]    conflict_cnt_q;

`ifdef FONT_ARB_RR_EN
  logic [1:0] ptr_q;
  logic [1:0] cand;

  // Walk from the farthest candidate back toward ptr_q so the nearest wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req_valid[cand]) begin
        grant     = 4'b0001 << cand;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= grant_idx + 2'd1;
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant     = 4'b0001 << k;
        grant_idx = 2'(k);
      end
    end
  end
`endif

  assign req_ready = reset ? 4'b0000 : grant;
  assign accept    = |req_ready;
  assign sel_addr  = req_addr[grant_idx*AW +: AW];
  assign multi_req = (req_valid & (req_valid - 4'd1)) != 4'd0;

  // Tag pipeline: stage 1 follows the ROM address, stage 2 the ROM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_q     <= '0;
      s1_v_q         <= 1'b0;
      s1_tag_q       <= '0;
      s2_v_q         <= 1'b0;
      s2_tag_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (accept) begin
        rom_addr_q <= sel_addr;
      end
      s1_v_q   <= accept;
      s1_tag_q <= grant_idx;
      s2_v_q   <= s1_v_q;
      s2_tag_q <= s1_tag_q;
      if (s2_v_q) begin
        rsp_valid_q <= 4'b0001 << s2_tag_q;
        rsp_data_q  <= rom_data;
      end else begin
        rsp_valid_q <= '0;
      end
      if (multi_req && conflict_cnt_q != 8'hFF) begin
        conflict_cnt_q <= conflict_cnt_q + 8'd1;
      end
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_font_rom_arb.sv
// Bench for font_rom_arb: reference arbiter model plus a response queue
// checked every cycle, and directed scenarios with fixed expected values.
module tb_font_rom_arb;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int W  = 2 + DW;

  logic            clk;
  logic            reset;
  logic [3:0]      req_valid;
  logic [4*AW-1:0] req_addr;
  logic [3:0]      req_ready;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [3:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [7:0]      conflict_cnt;

  int total = 0;
  int bad   = 0;

  font_rom_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .conflict_cnt(conflict_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 11'h2A3) return 8'h5C;
    return a[7:0] ^ {a[10:8], a[10:6]};
  endfunction

  initial rom_data = '0;
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
`ifdef FONT_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (v[idx]) return 4'b0001 << idx;
    end
`else
    idx = p;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) return 4'b0001 << k;
    end
`endif
    return 4'b0000;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return 2'(k);
    return 2'd0;
  endfunction

  logic [1:0]    m_ptr;
  logic          m_s1, m_s2, m_rsp;
  logic [1:0]    m_rtag;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_cnt;
  logic [3:0]    m_g;
  logic [1:0]    m_gi;
  logic [AW-1:0] m_ga;
  logic [W-1:0]  exp_q[$];

  assign m_g  = model_grant(req_valid, m_ptr);
  assign m_gi = onehot_idx(m_g);
  assign m_ga = req_addr[32'(m_gi)*AW +: AW];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr <= '0; m_s1 <= 1'b0; m_s2 <= 1'b0; m_rsp <= 1'b0;
      m_rtag <= '0; m_rdata <= '0; m_addr <= '0; m_cnt <= '0;
      exp_q.delete();
    end else begin
      m_s1  <= (m_g != 4'b0000);
      m_s2  <= m_s1;
      m_rsp <= m_s2;
      if (m_s2 && exp_q.size() > 0) begin
        m_rtag  <= exp_q[0][W-1:DW];
        m_rdata <= exp_q[0][DW-1:0];
        exp_q.pop_front();
      end
      if (m_g != 4'b0000) begin
        exp_q.push_back({m_gi, rom_fn(m_ga)});
        m_addr <= m_ga;
        m_ptr  <= m_gi + 2'd1;
      end
      if ($countones(req_valid) >= 2 && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
    end
  end

  // ---------------- cycle step with scoreboard check ----------------
  task automatic tick();
    logic [3:0] exp_rv;
    @(negedge clk);
    if (!reset) begin
      exp_rv = m_rsp ? (4'b0001 << m_rtag) : 4'b0000;
      total++;
      if (req_ready !== m_g) begin
        bad++; $display("FAIL sb_ready t=%0t got=%b exp=%b", $time, req_ready, m_g);
      end
      total++;
      if (rsp_valid !== exp_rv) begin
        bad++; $display("FAIL sb_rsp_valid t=%0t got=%b exp=%b", $time, rsp_valid, exp_rv);
      end
      total++;
      if (rsp_data !== m_rdata) begin
        bad++; $display("FAIL sb_rsp_data t=%0t got=%h exp=%h", $time, rsp_data, m_rdata);
      end
      total++;
      if (rom_addr !== m_addr) begin
        bad++; $display("FAIL sb_rom_addr t=%0t got=%h exp=%h", $time, rom_addr, m_addr);
      end
      total++;
      if (conflict_cnt !== m_cnt) begin
        bad++; $display("FAIL sb_conflict t=%0t got=%0d exp=%0d", $time, conflict_cnt, m_cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    total++;
    if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    total++;
    if (rom_addr !== 11'h000) begin bad++; $display("FAIL reset_rom_addr got=%h exp=000", rom_addr); end
    total++;
    if (conflict_cnt !== 8'd0) begin bad++; $display("FAIL reset_conflict got=%0d exp=0", conflict_cnt); end
    req_valid = 4'b0000;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_addr(2, 11'h2A3);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    total++;
    if (rom_addr !== 11'h2A3) begin bad++; $display("FAIL single_rom_addr got=%h exp=2a3", rom_addr); end
    tick();
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_early got=%b exp=0000", rsp_valid); end
    tick();
    total++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 8'h5C) begin
      bad++; $display("FAIL single_rsp got=%b/%h exp=0100/5c", rsp_valid, rsp_data);
    end
    tick();
    total++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 8'h5C) begin
      bad++; $display("FAIL single_after got=%b/%h exp=0000/5c", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_all_request();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, AW'($urandom_range(0, 2047)));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
`ifdef FONT_ARB_RR_EN
      exp_g = 4'b0001 << (i % 4);
`else
      exp_g = 4'b0001;
`endif
      #1;
      total++;
      if (req_ready !== exp_g) begin bad++; $display("FAIL all_grant%0d got=%b exp=%b", i, req_ready, exp_g); end
      tick();
    end
    req_valid = 4'b0000;
    total++;
    if (conflict_cnt !== 8'd8) begin bad++; $display("FAIL all_conflict got=%0d exp=8", conflict_cnt); end
    repeat (3) tick();
  endtask

  task automatic test_saturate();
    do_reset();
    set_addr(0, 11'h011);
    set_addr(1, 11'h122);
    req_valid = 4'b0011;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) begin
        total++;
        if (conflict_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", conflict_cnt); end
      end
      if (i == 255 || i == 300) begin
        total++;
        if (conflict_cnt !== 8'd255) begin bad++; $display("FAIL sat_255_at%0d got=%0d exp=255", i, conflict_cnt); end
      end
    end
    req_valid = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a1, b3, c1;
    do_reset();
    a1 = 11'h101; b3 = 11'h3F0; c1 = 11'h055;
    set_addr(1, a1);
    req_valid = 4'b0010;
    tick();
    set_addr(3, b3);
    req_valid = 4'b1000;
    tick();
    set_addr(1, c1);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    total++;
    if (rsp_valid !== 4'b0010 || rsp_data !== rom_fn(a1)) begin
      bad++; $display("FAIL b2b_rsp0 got=%b/%h exp=0010/%h", rsp_valid, rsp_data, rom_fn(a1));
    end
    tick();
    total++;
    if (rsp_valid !== 4'b1000 || rsp_data !== rom_fn(b3)) begin
      bad++; $display("FAIL b2b_rsp1 got=%b/%h exp=1000/%h", rsp_valid, rsp_data, rom_fn(b3));
    end
    tick();
    total++;
    if (rsp_valid !== 4'b0010 || rsp_data !== rom_fn(c1)) begin
      bad++; $display("FAIL b2b_rsp2 got=%b/%h exp=0010/%h", rsp_valid, rsp_data, rom_fn(c1));
    end
    tick();
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL b2b_idle got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    set_addr(3, 11'h2F1);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_data !== 8'h00 ||
        rom_addr !== 11'h000 || conflict_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_reset_outputs got=%b/%b/%h/%h/%0d exp=0/0/0/0/0",
                      req_ready, rsp_valid, rsp_data, rom_addr, conflict_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_addr(0, 11'h4C7);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    total++;
    if (rom_addr !== 11'h4C7 || rsp_valid !== 4'b0000) begin
      bad++; $display("FAIL mid_first_accept got=%h/%b exp=4c7/0000", rom_addr, rsp_valid);
    end
    tick();
    total++;
    if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_stale_rsp got=%b exp=0000", rsp_valid); end
    tick();
    total++;
    if (rsp_valid !== 4'b0001 || rsp_data !== rom_fn(11'h4C7)) begin
      bad++; $display("FAIL mid_rsp got=%b/%h exp=0001/%h", rsp_valid, rsp_data, rom_fn(11'h4C7));
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] acc;
    for (int c = 0; c < 200; c++) begin
      acc = model_grant(req_valid, m_ptr);
      tick();
      for (int i = 0; i < 4; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_addr(i, AW'($urandom_range(0, 2047)));
        end
      end
    end
    req_valid = 4'b0000;
    repeat (4) tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    req_valid = 4'b0000;
    req_addr = '0;
    #1;
    reset = 1'b1;
    test_reset();
    test_single();
    test_all_request();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
